// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request and response handshake with fixed latency.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned or out-of-range byte addresses with resp_err.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                  state_r;
    state_t                  state_s;
    logic [3:0]              cnt_r;
    logic                    wr_r;
    logic                    bad_r;
    logic                    bad_s;
    logic [DEPTH_LOG2-1:0]   idx_r;
    logic [31:0]             wdata_r;
    logic                    accept_s;
    logic                    fire_s;
    logic                    ready_s;
    logic                    valid_s;
    logic [31:0]             rdata_s;
    logic                    err_s;
    logic [31:0]             mem_r [0:(1 << DEPTH_LOG2) - 1];

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_s = (req_addr[1:0] != 2'b00) || ((req_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
`else
    logic addr_unused_s;
    assign bad_s         = 1'b0;
    assign addr_unused_s = ^{req_addr[1:0], (req_addr >> (DEPTH_LOG2 + 2))};
`endif

    assign accept_s = (state_r == IDLE) && req_valid;
    // fire_s marks the edge that moves WAIT into RESP: memory access happens here
    assign fire_s   = (state_r == WAIT) && (cnt_r == 4'd0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) state_s = WAIT;
                else           state_s = IDLE;
            end
            WAIT: begin
                if (cnt_r == 4'd0) state_s = RESP;
                else               state_s = WAIT;
            end
            RESP: begin
                if (resp_ready) state_s = IDLE;
                else            state_s = RESP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        ready_s = (state_s == IDLE);
        valid_s = (state_s == RESP);
        rdata_s = resp_rdata;
        err_s   = resp_err;
        if (fire_s) begin
            err_s = bad_r;
            if (!wr_r && !bad_r) rdata_s = mem_r[idx_r];
            else                 rdata_s = 32'd0;
        end else if ((state_r == RESP) && resp_ready) begin
            rdata_s = 32'd0;
            err_s   = 1'b0;
        end else begin
            rdata_s = resp_rdata;
            err_s   = resp_err;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            req_ready  <= ready_s;
            resp_valid <= valid_s;
            resp_rdata <= rdata_s;
            resp_err   <= err_s;
        end
    end

    // Latency counter and request capture at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= 4'd0;
            wr_r    <= 1'b0;
            bad_r   <= 1'b0;
            idx_r   <= '0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            cnt_r   <= CNT_LOAD;
            wr_r    <= req_write;
            bad_r   <= bad_s;
            idx_r   <= req_addr[DEPTH_LOG2+1:2];
            wdata_r <= req_wdata;
        end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Storage array: never reset, written only on a clean store entering RESP
    always_ff @(posedge clk) begin
        if (!reset && fire_s && wr_r && !bad_r) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LATENCY=2, DEPTH_LOG2=10); expectations follow MEM_ALIGN_CHECK_EN.
module tb_mem_responder;

    localparam int LAT = 2;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks;
    int errors;

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, WAIT for LAT edges, hold RESP for 'hold' cycles, then handshake.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold, input bit scramble);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b0;
        check_eq({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        if (!scramble) req_valid = 1'b0;
        check_eq({tag, "_wait_ready"}, {31'd0, req_ready}, 32'd0);
        check_eq({tag, "_wait_valid"}, {31'd0, resp_valid}, 32'd0);
        for (int i = 0; i < LAT; i++) begin
            if (scramble) begin
                req_addr  = 32'h0000_0034;
                req_wdata = $urandom;
                req_write = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (i < LAT - 1) check_eq({tag, "_lat_early"}, {31'd0, resp_valid}, 32'd0);
        end
        check_eq({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check_eq({tag, "_rdata"}, resp_rdata, exp_rdata);
        check_eq({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            check_eq({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
            check_eq({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
            check_eq({tag, "_hold_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check_eq({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
        check_eq({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
        check_eq({tag, "_done_rdata"}, resp_rdata, 32'd0);
        check_eq({tag, "_done_err"}, {31'd0, resp_err}, 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Store then load, including latency and handshake checks
        do_req("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, 1'b0);
        do_req("ld10", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);

        // Backpressure: response held for 5 cycles
        do_req("bp", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 5, 1'b0);

        // Reset abort of a store in WAIT
        do_req("st20z", 1'b1, 32'h0000_0020, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
        check_eq("abort_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("abort_rdata", resp_rdata, 32'd0);
        check_eq("abort_err", {31'd0, resp_err}, 32'd0);
        do_req("ld20", 1'b0, 32'h0000_0020, 32'd0, 32'd0, 1'b0, 0, 1'b0);

        // Misaligned store to 0x22 against word 8
        do_req("st20a", 1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'd0, 1'b0, 0, 1'b0);
        do_req("st22", 1'b1, 32'h0000_0022, 32'h1111_2222, 32'd0, ALIGN_EN, 0, 1'b0);
        do_req("ld20b", 1'b0, 32'h0000_0020, 32'd0,
               ALIGN_EN ? 32'hAAAA_5555 : 32'h1111_2222, 1'b0, 0, 1'b0);

        // Out-of-range load at 0x1000 against word 0
        do_req("st00", 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'd0, 1'b0, 0, 1'b0);
        do_req("ld1000", 1'b0, 32'h0000_1000, 32'd0,
               ALIGN_EN ? 32'd0 : 32'h0BAD_F00D, ALIGN_EN, 0, 1'b0);

        // Request inputs scrambled during WAIT/RESP must not leak into the transaction
        do_req("st34z", 1'b1, 32'h0000_0034, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        do_req("st30s", 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 32'd0, 1'b0, 1, 1'b1);
        do_req("ld30", 1'b0, 32'h0000_0030, 32'd0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
        do_req("ld34", 1'b0, 32'h0000_0034, 32'd0, 32'd0, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
